// File: rtl/taiga_types.sv
// rtl/taiga_types.sv - shared AXI encodings for the taiga memory slave
package taiga_types;

    localparam int         AXI_ID_W    = 6;
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    // WRAP and the reserved encoding both step like INCR; only FIXED holds the index
    function automatic logic burst_advances(input logic [1:0] burst);
        return burst != AXI_BURST_FIXED;
    endfunction

endpackage

// File: rtl/taiga_axi_mem_slave_ram.sv
// rtl/taiga_axi_mem_slave_ram.sv - single-port byte-writable RAM with registered read
module taiga_axi_mem_slave_ram #(
    parameter int MEM_WORDS = 4096,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [3:0]       i_we,
    input  logic [IDX_W-1:0] i_addr,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [MEM_WORDS];
    logic [31:0] r_rdata;

    assign o_rdata = r_rdata;

    // Read-first port: per-byte write enables and a one-cycle registered read
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/taiga_axi_mem_slave.sv
// rtl/taiga_axi_mem_slave.sv - one-transaction-at-a-time AXI4 slave backed by block RAM
module taiga_axi_mem_slave
    import taiga_types::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int MEM_WORDS          = 4096
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,
    input  logic [2:0]                      s_axi_arsize,
    input  logic [1:0]                      s_axi_arburst,
    input  logic [AXI_ID_W-1:0]             s_axi_arid,

    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rlast,
    output logic [AXI_ID_W-1:0]             s_axi_rid,

    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,
    input  logic [2:0]                      s_axi_awsize,
    input  logic [1:0]                      s_axi_awburst,
    input  logic [AXI_ID_W-1:0]             s_axi_awid,

    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,

    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    output logic [1:0]                      s_axi_bresp,
    output logic [AXI_ID_W-1:0]             s_axi_bid
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;

    state_t              r_state;
    logic                r_ready;
    logic                r_rvalid;
    logic                r_rlast;
    logic                r_wready;
    logic                r_bvalid;
    axi_resp_t           r_rresp;
    axi_resp_t           r_bresp;
    logic [AXI_ID_W-1:0] r_id;
    logic [7:0]          r_len;
    logic [7:0]          r_beat;
    logic [IDX_W-1:0]    r_idx;
    logic                r_fixed;
    logic                r_size_err;
    logic                r_overrun;

    logic                w_aw_hs;
    logic                w_ar_hs;
    logic [IDX_W-1:0]    w_aw_idx;
    logic [IDX_W-1:0]    w_ar_idx;
    logic [IDX_W-1:0]    w_idx_next;
    logic [7:0]          w_beat_next;
    logic                w_ram_en;
    logic [3:0]          w_ram_we;
    logic [IDX_W-1:0]    w_ram_addr;
    logic [31:0]         w_ram_rdata;

    // Writes win a same-cycle collision, so arready is masked by awvalid
    assign w_aw_hs     = r_ready & s_axi_awvalid;
    assign w_ar_hs     = r_ready & s_axi_arvalid & ~s_axi_awvalid;
    assign w_aw_idx    = IDX_W'(s_axi_awaddr >> 2);
    assign w_ar_idx    = IDX_W'(s_axi_araddr >> 2);
    assign w_idx_next  = r_fixed ? r_idx : r_idx + IDX_W'(1);
    assign w_beat_next = r_beat + 8'd1;

    assign s_axi_arready = r_ready & ~s_axi_awvalid;
    assign s_axi_awready = r_ready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rvalid ? C_S_AXI_DATA_WIDTH'(w_ram_rdata) : '0;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rid     = r_id;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_bid     = r_id;

    // RAM port steering: first read on issue, prefetch next word on each accepted
    // non-final beat, byte writes until the burst length is exhausted
    always_comb begin
        w_ram_en   = 1'b0;
        w_ram_we   = 4'b0000;
        w_ram_addr = r_idx;
        case (r_state)
            RD_ISSUE: w_ram_en = 1'b1;
            RD_DATA: begin
                if (s_axi_rready && !r_rlast) begin
                    w_ram_en   = 1'b1;
                    w_ram_addr = w_idx_next;
                end
            end
            WR_DATA: begin
                if (s_axi_wvalid && !r_overrun) begin
                    w_ram_en = 1'b1;
                    w_ram_we = 4'(s_axi_wstrb);
                end
            end
            default: ;
        endcase
        if (!rst) begin
            w_ram_en = 1'b0;
            w_ram_we = 4'b0000;
        end
    end

    taiga_axi_mem_slave_ram #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (32'(s_axi_wdata)),
        .o_rdata (w_ram_rdata)
    );

    // Transaction FSM with registered handshake and response outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_ready    <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_rresp    <= AXI_RESP_OKAY;
            r_bresp    <= AXI_RESP_OKAY;
            r_id       <= '0;
            r_len      <= '0;
            r_beat     <= '0;
            r_idx      <= '0;
            r_fixed    <= 1'b0;
            r_size_err <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_aw_hs) begin
                        r_ready    <= 1'b0;
                        r_wready   <= 1'b1;
                        r_idx      <= w_aw_idx;
                        r_len      <= s_axi_awlen;
                        r_beat     <= '0;
                        r_id       <= s_axi_awid;
                        r_fixed    <= !burst_advances(s_axi_awburst);
                        r_size_err <= (s_axi_awsize != AXI_SIZE_4B);
                        r_overrun  <= 1'b0;
                        r_state    <= WR_DATA;
                    end else if (w_ar_hs) begin
                        r_ready    <= 1'b0;
                        r_idx      <= w_ar_idx;
                        r_len      <= s_axi_arlen;
                        r_beat     <= '0;
                        r_id       <= s_axi_arid;
                        r_fixed    <= !burst_advances(s_axi_arburst);
                        r_size_err <= (s_axi_arsize != AXI_SIZE_4B);
                        r_state    <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    r_rvalid <= 1'b1;
                    r_rlast  <= (r_len == 8'd0);
                    r_rresp  <= r_size_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    r_state  <= RD_DATA;
                end
                RD_DATA: begin
                    if (s_axi_rready) begin
                        if (r_rlast) begin
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                            r_rresp  <= AXI_RESP_OKAY;
                            r_ready  <= 1'b1;
                            r_state  <= IDLE;
                        end else begin
                            r_beat  <= w_beat_next;
                            r_idx   <= w_idx_next;
                            r_rlast <= (w_beat_next == r_len);
                        end
                    end
                end
                WR_DATA: begin
                    if (s_axi_wvalid) begin
                        r_beat <= w_beat_next;
                        r_idx  <= w_idx_next;
                        if (r_beat == r_len && !s_axi_wlast) begin
                            r_overrun <= 1'b1;
                        end
                        if (s_axi_wlast) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_size_err || r_overrun || r_beat != r_len)
                                        ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                            r_state  <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid <= 1'b0;
                        r_bresp  <= AXI_RESP_OKAY;
                        r_ready  <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/taiga_axi_mem_slave.md
# taiga_axi_mem_slave

AXI4 slave memory that consumes the core's external AXI master port (arid/awid/rid/bid, 6-bit IDs) and serves it from on-chip block RAM. It stands in for DDR/interconnect in FPGA builds and simulation, directly downstream of the Xilinx core wrapper. It handles one transaction at a time (INCR and FIXED bursts, byte strobes) and returns correct IDs, rlast and responses.

## Interface
Parameters:
- C_S_AXI_ADDR_WIDTH, 32, AXI address width
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported
- MEM_WORDS, 4096, RAM depth in 32-bit words; power of two

Ports:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- s_axi_arvalid / s_axi_arready  in/out  1  read address handshake
- s_axi_araddr  in  ADDR_WIDTH  read byte address
- s_axi_arlen  in  8  beats minus one
- s_axi_arsize  in  3  beat size; 3'b010 supported
- s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP (treated as INCR)
- s_axi_arid  in  6  read ID
- s_axi_rvalid / s_axi_rready  out/in  1  read data handshake
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  00 OKAY, 10 SLVERR
- s_axi_rlast  out  1  final beat
- s_axi_rid  out  6  echo of arid
- s_axi_awvalid / s_axi_awready  in/out  1  write address handshake
- s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awid  in  ADDR_WIDTH/8/3/2/6  same as AR channel
- s_axi_wvalid / s_axi_wready  in/out  1  write data handshake
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8  byte enables
- s_axi_wlast  in  1  final write beat
- s_axi_bvalid / s_axi_bready  out/in  1  write response handshake
- s_axi_bresp  out  2  write response
- s_axi_bid  out  6  echo of awid

## Operation
- FSM states: IDLE, RD_ISSUE, RD_DATA, WR_DATA, WR_RESP.
- IDLE: arready=awready=1. If awvalid and arvalid arrive together, the write wins and arready drops in that cycle. On a handshake, latch addr, len, size, burst and id; clear the beat counter.
- Word index = addr[log2(MEM_WORDS)+1:2]. It wraps modulo MEM_WORDS, and out-of-range addresses alias. INCR and WRAP advance the index by 1 per beat; FIXED holds it.
- size ≠ 3'b010: the transfer still completes with word semantics, but resp=SLVERR on every rresp beat and on bresp.
- RD_ISSUE: issue the RAM read, go to RD_DATA. RD_DATA: rvalid=1, rid=latched id, rlast=(beat==len). On each r handshake, read the next word in the same cycle. rdata/rvalid/rlast stay stable while rready is low. After the last beat, return to IDLE.
- WR_DATA: wready=1. Each w handshake writes the RAM under wstrb and increments the beat counter. Leave on wlast. If wlast is not coincident with beat==len, bresp=SLVERR. Beats beyond len are accepted while waiting for wlast, but only indices up to len are written.
- WR_RESP: bvalid=1, bid=latched id, until bready; then go to IDLE.
- Reset (rst=0 at an edge): FSM→IDLE. Next cycle every output is 0: all ready/valid, rdata, rresp, rlast, rid, bresp, bid. RAM contents are preserved. A mid-burst reset abandons the burst silently.

## Timing
- AR handshake at edge N → rvalid rises at edge N+2. With rready held high, one beat per cycle thereafter.
- Last r handshake at edge M → arready/awready high at edge M+1.
- AW handshake at edge N → wready high at edge N+1. The wlast handshake at edge M → bvalid at M+1. b handshake at K → IDLE (ready high) at K+1.
- Writes are visible to any read issued after bvalid.

## Structure
- Shared package taiga_types: axi_burst_t (FIXED/INCR/WRAP) and axi_resp_t (OKAY/EXOKAY/SLVERR/DECERR) encodings, plus a constant AXI_ID_W=6.
- Sub-module taiga_axi_mem_slave_ram: single-port, MEM_WORDS×32, 4 byte write-enables, 1-cycle registered read, inferable as Xilinx BRAM.

## Test plan
- Single write: awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, awid=5 → bresp=OKAY, bid=5. Then arlen=0 read of 0x10 → rdata=0xDEADBEEF, rlast=1, rid=5.
- INCR burst: write 8 beats at 0x100 with values 0..7, read back with arlen=7, rready held high → 8 consecutive rvalid cycles, rlast only on beat 7.
- Byte strobes: 0xFFFFFFFF at 0x20, then wstrb=4'b0101 with 0x00000000 → read returns 0xFF00FF00.
- Backpressure and collision: arvalid and awvalid in the same cycle → write completes first. rready toggled randomly → rdata stable while stalled, no lost beats.
- Errors and wrap: arsize=3'b001 → rresp=SLVERR. Early wlast → bresp=SLVERR. An INCR burst crossing MEM_WORDS*4 wraps to index 0.
- Reset mid-burst (after beat 3 of an arlen=7 read) → all outputs 0 next cycle. A following read returns the original RAM data.
